// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART transmit and receive paths.
package uart_pkg;
  localparam int UART_DATA_BITS = 8;
  localparam int UART_CLKS_PER_BIT_DEF = 32;
  localparam logic UART_IDLE = 1'b1;
  localparam logic UART_START = 1'b0;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;
endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: free-running 0..CLKS_PER_BIT-1 bit-period counter with sync clear and bit_end strobe.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic bit_end_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  logic [CW-1:0] cnt_q, cnt_d;
  assign bit_end_o = !clr_i && cnt_q == CW'(CLKS_PER_BIT - 1);
  always_comb begin
    cnt_d = clr_i || bit_end_o ? '0 : cnt_q + CW'(1);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: valid/ready byte in, one async frame out on Tx (start, 8 data LSB first, stop).
// Define UART_TX_PARITY_EN to insert an even parity bit before the stop bit (8E1 instead of 8N1).
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF,
  parameter int DATA_BITS = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_done,
  output logic                 Tx,
  output logic                 busy
);
  localparam int IW = $clog2(DATA_BITS);
  uart_state_e state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [IW-1:0] idx_q, idx_d;
  logic tx_q, tx_d, bit_end;
`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;
`endif
  assign tx_ready = state_q == IDLE;
  assign busy = !tx_ready;
  assign tx_done = state_q == STOP && bit_end;
  assign Tx = tx_q;
  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (tx_ready),
    .bit_end_o(bit_end)
  );
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d = idx_q;
`ifdef UART_TX_PARITY_EN
    par_d = par_q;
`endif
    case (state_q)
      IDLE: if (tx_valid) begin
        state_d = START;
        shreg_d = tx_data;
        idx_d = '0;
`ifdef UART_TX_PARITY_EN
        par_d = ^tx_data;
`endif
      end
      START: if (bit_end) state_d = DATA;
      DATA: if (bit_end) begin
        shreg_d = shreg_q >> 1;
        idx_d = idx_q + IW'(1);
`ifdef UART_TX_PARITY_EN
        if (idx_q == IW'(DATA_BITS - 1)) state_d = PARITY;
`else
        if (idx_q == IW'(DATA_BITS - 1)) state_d = STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) state_d = STOP;
`endif
      STOP: if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Line level is decoded from the next state so Tx itself comes straight from a flop.
`ifdef UART_TX_PARITY_EN
    tx_d = state_d == START ? UART_START : state_d == DATA ? shreg_d[0] : state_d == PARITY ? par_d : UART_IDLE;
`else
    tx_d = state_d == START ? UART_START : state_d == DATA ? shreg_d[0] : UART_IDLE;
`endif
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q <= '0;
      tx_q <= UART_IDLE;
`ifdef UART_TX_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q <= idx_d;
      tx_q <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q <= par_d;
`endif
    end
  end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: table, corner-case and random frames checked against a per-cycle line model.
module tb_uart_tx_frame;
  localparam int CPB = 32;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FLEN = (10 + PAR) * CPB;
  typedef struct {
    logic [7:0] d;
    logic [9:0] seq;
    logic       par;
  } vec_t;
  logic clk = 0, rst = 1, tx_valid = 0;
  logic [7:0] tx_data = 0;
  logic tx_ready, tx_done, Tx, busy;
  int total = 0, bad = 0;
  logic txs[$], dns[$], rdy[$], bsy[$], ec[$];
  vec_t tab[8];
  uart_tx_frame #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_done (tx_done),
    .Tx      (Tx),
    .busy    (busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask
  task automatic add_level(input logic lv, input int n);
    repeat (n) ec.push_back(lv);
  endtask
  task automatic add_model(input logic [7:0] d);
    add_level(1'b0, CPB);
    for (int i = 0; i < 8; i++) add_level(d[i], CPB);
    if (PAR == 1) add_level(logic'($countones(d) % 2), CPB);
    add_level(1'b1, CPB);
  endtask
  task automatic add_tab(input logic [9:0] seq, input logic par);
    for (int i = 9; i >= 1; i--) add_level(seq[i], CPB);
    if (PAR == 1) add_level(par, CPB);
    add_level(seq[0], CPB);
  endtask
  task automatic send(input logic [7:0] d, input logic hold, input logic [7:0] nxt);
    int w = 0;
    @(negedge clk);
    while (tx_ready !== 1'b1 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    chk("ready_before_send", tx_ready, 1);
    tx_data = d;
    tx_valid = 1;
    @(posedge clk);
    #1;
    tx_valid = hold;
    tx_data = nxt;
  endtask
  task automatic capture(input int n, input int pulse_at, input int drop_at);
    txs.delete(); dns.delete(); rdy.delete(); bsy.delete();
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      txs.push_back(Tx);
      dns.push_back(tx_done);
      rdy.push_back(tx_ready);
      bsy.push_back(busy);
      if (k == pulse_at) begin
        tx_valid = 1;
        tx_data = 8'hFF;
      end
      if (k == pulse_at + 1 || k == drop_at) tx_valid = 0;
    end
  endtask
  task automatic check_stream(input string name);
    int mism = 0, first = 0;
    for (int k = 0; k < txs.size(); k++) begin
      if (k >= ec.size() || txs[k] !== ec[k]) begin
        if (mism == 0) first = k + 1;
        mism++;
      end
    end
    chk($sformatf("%s_tx_mismatches_first_at_%0d", name, first), mism, 0);
  endtask
  task automatic check_done(input string name, input int cnt, input int last);
    int c = 0, l = 0;
    for (int k = 0; k < dns.size(); k++) if (dns[k] !== 1'b0) begin
      c++;
      l = k + 1;
    end
    chk({name, "_done_count"}, c, cnt);
    chk({name, "_done_cycle"}, l, last);
  endtask
  task automatic check_hs(input string name);
    int m = 0;
    for (int k = 0; k < FLEN; k++) if (rdy[k] !== 1'b0 || bsy[k] !== 1'b1) m++;
    chk({name, "_ready_busy_in_frame_errs"}, m, 0);
    chk({name, "_ready_after"}, rdy[FLEN], 1);
    chk({name, "_busy_after"}, bsy[FLEN], 0);
  endtask
  initial begin
    logic [7:0] d;
    int gap, s;
    tab[0] = '{8'h21, 10'b0100001001, 1'b0};
    tab[1] = '{8'h2F, 10'b0111101001, 1'b1};
    tab[2] = '{8'hA5, 10'b0101001011, 1'b0};
    tab[3] = '{8'h55, 10'b0101010101, 1'b0};
    tab[4] = '{8'h00, 10'b0000000001, 1'b0};
    tab[5] = '{8'hFF, 10'b0111111111, 1'b0};
    tab[6] = '{8'h80, 10'b0000000011, 1'b1};
    tab[7] = '{8'h01, 10'b0100000001, 1'b1};
    #2 rst = 0;
    repeat (2) @(negedge clk);
    chk("reset_tx", Tx, 1);
    chk("reset_ready", tx_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", tx_done, 0);
    rst = 1;
    for (int i = 0; i < 8; i++) begin
      send(tab[i].d, 1'b0, 8'($urandom));
      capture(FLEN + 1, -10, -10);
      ec.delete();
      add_tab(tab[i].seq, tab[i].par);
      add_level(1'b1, 1);
      check_stream($sformatf("tab_%02h", tab[i].d));
      check_done($sformatf("tab_%02h", tab[i].d), 1, FLEN);
      check_hs($sformatf("tab_%02h", tab[i].d));
    end
    send(8'h21, 1'b0, 8'h00);
    capture(FLEN + 1 + CPB, 100, -10);
    ec.delete();
    add_tab(tab[0].seq, tab[0].par);
    add_level(1'b1, 1 + CPB);
    check_stream("ignore_busy_valid");
    check_done("ignore_busy_valid", 1, FLEN);
    check_hs("ignore_busy_valid");
    send(8'h21, 1'b1, 8'h2F);
    capture(2 * FLEN + 1 + CPB, -10, FLEN + 2);
    ec.delete();
    add_tab(tab[0].seq, tab[0].par);
    add_level(1'b1, 1);
    add_tab(tab[1].seq, tab[1].par);
    add_level(1'b1, 1 + CPB);
    check_stream("back_to_back");
    check_done("back_to_back", 2, 2 * FLEN + 1);
    s = FLEN - CPB;
    while (s < txs.size() && txs[s] !== 1'b0) s++;
    gap = 0;
    for (int k = s - 1; k >= 0 && txs[k] === 1'b1; k--) gap++;
    chk("back_to_back_gap", gap, CPB + 1);
    send(8'h55, 1'b0, 8'hAA);
    capture(4 * CPB + 12, -10, -10);
    ec.delete();
    add_tab(tab[3].seq, tab[3].par);
    check_stream("pre_reset_0x55");
    chk("pre_reset_tx_low", Tx, 0);
    #2 rst = 0;
    #1;
    chk("async_reset_tx", Tx, 1);
    chk("async_reset_busy", busy, 0);
    chk("async_reset_ready", tx_ready, 1);
    chk("async_reset_done", tx_done, 0);
    repeat (3) @(negedge clk);
    rst = 1;
    send(8'h55, 1'b0, 8'h00);
    capture(FLEN + 1, -10, -10);
    ec.delete();
    add_tab(tab[3].seq, tab[3].par);
    add_level(1'b1, 1);
    check_stream("after_reset_0x55");
    check_done("after_reset_0x55", 1, FLEN);
    check_hs("after_reset_0x55");
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 5)) @(negedge clk);
      send(d, 1'b0, 8'($urandom));
      capture(FLEN + 1, -10, -10);
      ec.delete();
      add_model(d);
      add_level(1'b1, 1);
      check_stream($sformatf("rand%0d_%02h", i, d));
      check_done($sformatf("rand%0d_%02h", i, d), 1, FLEN);
      check_hs($sformatf("rand%0d_%02h", i, d));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Serial transmitter for the board's UART link, the transmit counterpart of the channel-processor receive path. It accepts a byte over a valid/ready handshake and shifts it out on `Tx` as one asynchronous frame: start bit, 8 data bits LSB first, optional even parity, one stop bit. It sits beside the receiver in `top` and returns status and channel readback to the host at the same bit rate the receiver samples, 32 clocks per bit.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 32: clock cycles per serial bit; legal range ≥ 2.
- `DATA_BITS`, default 8: payload width; fixed at 8 in this design.

Ports:
- `clk`  in  1  system clock, single clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `tx_data`  in  8  byte to send; sampled only on handshake.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  block can accept a byte this cycle.
- `tx_done`  out  1  one-cycle pulse at the end of the stop bit.
- `Tx`  out  1  serial line; idles high.
- `busy`  out  1  a frame is in progress.

## Operation
- Handshake: a byte is accepted on the rising `clk` edge where `tx_valid` and `tx_ready` are both 1. `tx_data` is latched into the shift register at that edge. Later changes to `tx_data` have no effect on the frame.
- `tx_ready` = 1 only in IDLE. `tx_valid` asserted while `tx_ready` = 0 is ignored and not queued.
- FSM states:
  - IDLE → START on accept.
  - START → DATA after `CLKS_PER_BIT` cycles.
  - DATA → PARITY after bit index 7 completes. With parity compiled out, DATA → STOP.
  - PARITY → STOP.
  - STOP → IDLE after `CLKS_PER_BIT` cycles.
- `Tx` per state: IDLE 1, START 0, DATA `shreg[0]`, PARITY XOR of the latched byte (even parity), STOP 1.
- The bit counter is 0..`CLKS_PER_BIT`-1 and wraps to 0 at each bit boundary. The bit index is 0..7.
- `busy` = 1 in every state except IDLE.
- Reset values: `Tx`=1, `tx_ready`=1, `busy`=0, `tx_done`=0, state IDLE, all counters 0.
- Reset mid-frame: `Tx` returns to 1 asynchronously. The frame is abandoned and not resumed. After `rst` is released the block is in IDLE and ready.

## Timing
- `Tx` is registered and glitch-free.
- The start bit drives `Tx` low starting the cycle after the accept edge.
- Each bit lasts exactly `CLKS_PER_BIT` cycles.
- Frame length is 11×`CLKS_PER_BIT` cycles with parity (352 at default) and 10×`CLKS_PER_BIT` without.
- `tx_done` pulses in the final cycle of STOP. The next cycle is IDLE with `tx_ready`=1.
- Back-to-back: with `tx_valid` held high, the next byte is accepted in the first IDLE cycle. The next start bit follows one cycle later, so the minimum line-high gap between frames is `CLKS_PER_BIT`+1 cycles.
- Accept-to-ready latency = frame length + 1 cycle.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - The PARITY state is present and transmits even parity.
  - 11-bit frame.
  - Matches the receiver's 8E1 format.
- `UART_TX_PARITY_EN` undefined:
  - No PARITY state; the FSM goes DATA → STOP.
  - 10-bit frame (8N1).
  - The parity logic is removed entirely.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - `UART_DATA_BITS` = 8;
  - `UART_CLKS_PER_BIT_DEF` = 32;
  - line level constants `UART_IDLE` = 1 and `UART_START` = 0.
  The receiver uses the same package.
- One sub-module, `uart_baud_cnt`: it counts 0..`CLKS_PER_BIT`-1, has a synchronous clear, and outputs a `bit_end` strobe. The FSM, shift register and parity stay in `uart_tx_frame`.

## Test plan
- Send 0x21 with parity enabled. Required: `Tx` holds 0,1,0,0,0,0,1,0,0,0,1, each level for 32 cycles; parity bit = 0; one `tx_done` pulse at cycle 352; `tx_ready` = 1 at cycle 353.
- Send 0x2F. Required: data bits 1,1,1,1,0,1,0,0 and parity bit = 1; a loopback into the receiver yields `debug_frame` = {1, 0x2F} with no parity error.
- Hold `tx_valid` high with 0x21 then 0x2F. Required: two complete frames; the gap between them is 33 cycles with `Tx` high; exactly two `tx_done` pulses.
- Pulse `tx_valid` with 0xFF in cycle 100 of a 0x21 frame. Required: ignored; only 0x21 is transmitted; `tx_ready` stays 0 until IDLE.
- Drop `rst` low during data bit 3 of 0x55. Required: `Tx`=1, `busy`=0 and `tx_ready`=1 immediately, with no clock edge needed; after release, a new 0x55 transmits correctly.
- Build without `UART_TX_PARITY_EN` and send 0xA5. Required: 10-bit frame 0,1,0,1,0,0,1,0,1,1 of 320 cycles; `tx_done` pulses at cycle 320.
